fetch_queue: RTL and testbench

- Instruction-fetch front end between the next-PC selection logic and the decoder.
- Holds the fetch PC and issues word reads to the synchronous instruction memory (1-cycle read latency).
- Buffers returned instructions with their PCs in a DEPTH-entry FIFO and presents them to the decoder over a valid/ready handshake.
- On a branch or jump redirect it flushes the queue and discards any in-flight read.

---
 rtl/fetch_queue.sv | 145 ++++++++++++++
 tb/tb_fetch_queue.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end between next-PC selection and the decoder.
//
// Holds the fetch PC and issues word reads to a synchronous instruction memory
// that has a 1-cycle read latency. Returned words are buffered with their PCs in
// a DEPTH-entry FIFO and handed to the decoder over a valid/ready handshake.
// A redirect flushes the queue and drops any read still in flight.
//
// Optional build macro: FETCH_BYPASS_EN
//   When defined, a read that returns while the queue is empty is presented to
//   the decoder in the same cycle. It is written into the FIFO only if the
//   decoder does not accept it in that cycle.
//
// Ports:
//   clk_i          rising-edge clock
//   reset_i        asynchronous reset, active low
//   mem_req_o      read request to instruction memory this cycle
//   mem_addr_o     word address, fetch_pc[ADDR_W+1:2]
//   mem_rdata_i    read data, valid the cycle after an accepted request
//   redirect_i     taken branch/jump: replace the fetch PC
//   redirect_pc_i  new byte PC (bits [1:0] ignored)
//   instr_o        instruction to decoder (NOP when not valid)
//   pc_o           byte PC of instr_o (0 when not valid)
//   valid_o        instr_o/pc_o valid
//   ready_i        decoder accepts this cycle
//   count_o        occupied FIFO entries
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned ADDR_W   = 14,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    output logic                     mem_req_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    input  logic [31:0]              mem_rdata_i,
    input  logic                     redirect_i,
    input  logic [31:0]              redirect_pc_i,
    output logic [31:0]              instr_o,
    output logic [31:0]              pc_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic          rsp_v;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc_mem    [DEPTH];

    logic          head_v;
    logic          byp_v;
    logic          push;
    logic          fifo_pop;
    logic [CW:0]   credit;

    // Byte-offset bits of a redirect target never reach the fetch PC.
    logic          unused_bits;
    assign unused_bits = ^redirect_pc_i[1:0];

    assign mem_addr_o = fetch_pc[ADDR_W+1:2];
    assign count_o    = count;

    always_comb begin
        head_v    = (count != '0);
`ifdef FETCH_BYPASS_EN
        byp_v     = !head_v && rsp_v;
`else
        byp_v     = 1'b0;
`endif
        // Credit counts the in-flight read against free space; a pop in the
        // same cycle is deliberately not credited.
        credit    = {1'b0, count} + {{CW{1'b0}}, rsp_v};
        mem_req_o = reset_i && !redirect_i && (credit < (CW+1)'(DEPTH));
        valid_o   = (head_v || byp_v) && !redirect_i;
        fifo_pop  = head_v && !redirect_i && ready_i;
        // A bypassed response consumed by the decoder is never written.
        push      = rsp_v && !redirect_i && !(byp_v && ready_i);

        instr_o   = NOP;
        pc_o      = '0;
        if (valid_o) begin
            if (head_v) begin
                instr_o = instr_mem[rd_ptr];
                pc_o    = pc_mem[rd_ptr];
            end else begin
                instr_o = mem_rdata_i;
                pc_o    = rsp_pc;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= '0;
            rsp_v    <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else if (redirect_i) begin
            fetch_pc <= {redirect_pc_i[31:2], 2'b00};
            rsp_v    <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (mem_req_o) begin
                fetch_pc <= fetch_pc + 32'd4;
                rsp_pc   <= fetch_pc;
                rsp_v    <= 1'b1;
            end else begin
                rsp_v    <= 1'b0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, fifo_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage carries no reset; count alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_mem[wr_ptr] <= mem_rdata_i;
            pc_mem[wr_ptr]    <= rsp_pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed stimulus with a PC-stream scoreboard.
// Memory word k holds 32'h1000_0000 + k. Build with FETCH_BYPASS_EN defined to
// exercise the bypass timing.
module tb_fetch_queue;

`ifdef FETCH_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_i;
    logic        reset_i;
    logic        mem_req_o;
    logic [13:0] mem_addr_o;
    logic [31:0] mem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        valid_o;
    logic        ready_i;
    logic [2:0]  count_o;

    int          checks;
    int          errors;
    int          pops;
    logic [31:0] exp_q[$];

    fetch_queue #(
        .DEPTH(4),
        .ADDR_W(14),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .mem_req_o(mem_req_o),
        .mem_addr_o(mem_addr_o),
        .mem_rdata_i(mem_rdata_i),
        .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .instr_o(instr_o),
        .pc_o(pc_o),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .count_o(count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Synchronous instruction memory, 1-cycle read latency.
    initial mem_rdata_i = '0;
    always @(posedge clk_i) begin
        if (mem_req_o) mem_rdata_i <= 32'h1000_0000 + {18'b0, mem_addr_o};
    end

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return 32'h1000_0000 + {18'b0, pc[15:2]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected delivery order starting at a given PC.
    task automatic seg(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(4 * i));
        pops = 0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: every accepted handshake is compared against the scoreboard.
    always @(negedge clk_i) begin
        if (reset_i && valid_o && ready_i) begin
            pops++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stream_extra: got pc %h expected none", pc_o);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("stream_pc", pc_o, e);
                chk("stream_instr", instr_o, instr_of(e));
            end
        end
    end

    // Asserts reset, checks reset outputs, releases it; returns settled in cycle 0.
    task automatic start_reset(input logic rdy);
        tick();
        reset_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        ready_i       = rdy;
        seg(32'h0);
        #1;
        chk("rst_req", 32'(mem_req_o), 0);
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_instr", instr_o, NOP);
        chk("rst_pc", pc_o, 0);
        chk("rst_count", 32'(count_o), 0);
        tick();
        tick();
        reset_i = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt_e [10];
        int req_e [10];
        cnt_e = '{0, 0, 1, 2, 3, 4, 4, 4, 4, 4};
        req_e = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
        checks        = 0;
        errors        = 0;
        pops          = 0;
        reset_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        ready_i       = 1'b0;

        // Reset then streaming fetch with ready held high.
        start_reset(1'b1);
        chk("A_req0", 32'(mem_req_o), 1);
        chk("A_addr0", {18'b0, mem_addr_o}, 0);
        chk("A_valid0", 32'(valid_o), 0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            #1;
            chk("A_addr", {18'b0, mem_addr_o}, 32'(k));
            chk("A_valid", 32'(valid_o), 32'(k >= 2 - BYP));
            if (k == 2 - BYP) chk("A_first_pc", pc_o, 0);
            if (k >= 2) chk("A_count", 32'(count_o), 32'(1 - BYP));
        end
        // Redirect during streaming.
        tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0200;
        seg(32'h200);
        #1;
        chk("A_rd_valid", 32'(valid_o), 0);
        chk("A_rd_req", 32'(mem_req_o), 0);
        tick();
        redirect_i = 1'b0;
        #1;
        chk("A_rd_count", 32'(count_o), 0);
        chk("A_rd_addr", {18'b0, mem_addr_o}, 32'h80);
        chk("A_rd_req1", 32'(mem_req_o), 1);
        chk("A_rd_valid1", 32'(valid_o), 0);
        for (int k = 2; k <= 6; k++) begin
            tick();
            #1;
            chk("A_rd_valid_k", 32'(valid_o), 32'(k >= 3 - BYP));
            if (k == 3 - BYP) chk("A_rd_first_pc", pc_o, 32'h200);
        end

        // Backpressure fills the queue, then drains with simultaneous push/pop.
        start_reset(1'b0);
        chk("B_count", 32'(count_o), 32'(cnt_e[0]));
        chk("B_req", 32'(mem_req_o), 32'(req_e[0]));
        for (int k = 1; k < 10; k++) begin
            tick();
            #1;
            chk("B_count", 32'(count_o), 32'(cnt_e[k]));
            chk("B_req", 32'(mem_req_o), 32'(req_e[k]));
        end
        tick();
        ready_i = 1'b1;
        #1;
        chk("B_full_req", 32'(mem_req_o), 0);
        chk("B_full_count", 32'(count_o), 4);
        chk("B_head_pc", pc_o, 0);
        tick();
        #1;
        chk("B_c11_count", 32'(count_o), 3);
        chk("B_c11_req", 32'(mem_req_o), 1);
        chk("B_c11_addr", {18'b0, mem_addr_o}, 4);
        tick();
        #1;
        chk("B_c12_count", 32'(count_o), 2);
        chk("B_c12_addr", {18'b0, mem_addr_o}, 5);
        for (int k = 0; k < 17; k++) begin
            tick();
            #1;
            chk("B_pushpop_count", 32'(count_o), 2);
        end
        @(negedge clk_i);
        #1;
        chk("B_pops", 32'(pops), 20);

        // Redirect with count=3 and a read in flight.
        start_reset(1'b0);
        for (int k = 1; k <= 4; k++) tick();
        #1;
        chk("C_count3", 32'(count_o), 3);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0103;
        ready_i       = 1'b1;
        seg(32'h100);
        #1;
        chk("C_rd_valid", 32'(valid_o), 0);
        chk("C_rd_req", 32'(mem_req_o), 0);
        tick();
        redirect_i = 1'b0;
        #1;
        chk("C_count0", 32'(count_o), 0);
        chk("C_addr", {18'b0, mem_addr_o}, 32'h40);
        chk("C_req", 32'(mem_req_o), 1);
        for (int k = 2; k <= 8; k++) begin
            tick();
            #1;
            chk("C_valid_k", 32'(valid_o), 32'(k >= 3 - BYP));
            if (k == 3 - BYP) chk("C_first_pc", pc_o, 32'h100);
        end

        // Asynchronous reset mid-cycle with count=3.
        start_reset(1'b0);
        for (int k = 1; k <= 4; k++) tick();
        #1;
        chk("D_count3", 32'(count_o), 3);
        chk("D_valid", 32'(valid_o), 1);
        #1;
        reset_i = 1'b0;
        #1;
        chk("D_async_valid", 32'(valid_o), 0);
        chk("D_async_req", 32'(mem_req_o), 0);
        chk("D_async_count", 32'(count_o), 0);
        chk("D_async_instr", instr_o, NOP);
        ready_i = 1'b1;
        seg(32'h0);
        tick();
        reset_i = 1'b1;
        #1;
        chk("D_restart_req", 32'(mem_req_o), 1);
        chk("D_restart_addr", {18'b0, mem_addr_o}, 0);
        for (int k = 1; k <= 10; k++) tick();
        @(negedge clk_i);
        #1;
        chk("D_pops", 32'(pops), 32'(9 + BYP));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
